// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the five-stage core: T_new/T_use widths,
// MDU latencies, MD-op encoding and the register-hazard compare.
package pipe_pkg;

    localparam int         T_NEW_W          = 3;
    localparam logic [2:0] T_USE_NONE       = 3'b111;
    localparam int         MULT_CYCLES_DEF  = 5;
    localparam int         DIV_CYCLES_DEF   = 10;

    typedef enum logic {
        MD_MULT = 1'b0,
        MD_DIV  = 1'b1
    } md_op_e;

    // T_USE_NONE is the largest T_use, so it can never be below any T_new;
    // T_new == 0 can never exceed any T_use, which leaves it to forwarding.
    function automatic logic reg_hazard(
        input logic [4:0]         src,
        input logic [T_NEW_W-1:0] t_use,
        input logic [4:0]         dst,
        input logic [T_NEW_W-1:0] t_new,
        input logic               we
    );
        return we && (src == dst) && (src != 5'd0) && (t_use < t_new);
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// MDU busy timer: loadable down-counter with busy/done decode.
// A start while busy reloads, so an aborted operation never reports done.
module md_busy_timer
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (start)
            cnt <= (md_op_e'(is_div) == MD_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // Decoded straight from cnt so an async reset drops both at once.
    assign busy = (cnt != '0);
    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/stall_ctrl.sv
// D-stage hazard detector and stall controller: register hazards against E/M,
// MDU occupancy hazard, and a saturating count of stalled cycles.
module stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         D_rs,
    input  logic [4:0]         D_rt,
    input  logic [T_NEW_W-1:0] D_T_use_rs,
    input  logic [T_NEW_W-1:0] D_T_use_rt,
    input  logic               D_is_md,
    input  logic [4:0]         E_Reg_Addr,
    input  logic [T_NEW_W-1:0] E_T_new,
    input  logic               E_Reg_W,
    input  logic [4:0]         M_Reg_Addr,
    input  logic [T_NEW_W-1:0] M_T_new,
    input  logic               M_Reg_W,
    input  logic               E_md_start,
    input  logic               E_md_is_div,
    output logic               stall,
    output logic               md_busy,
    output logic               md_done,
    output logic [31:0]        stall_cnt
);

    logic haz_e_rs, haz_e_rt, haz_m_rs, haz_m_rt, haz_md;

    md_busy_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (E_md_start),
        .is_div(E_md_is_div),
        .busy  (md_busy),
        .done  (md_done)
    );

    assign haz_e_rs = reg_hazard(D_rs, D_T_use_rs, E_Reg_Addr, E_T_new, E_Reg_W);
    assign haz_e_rt = reg_hazard(D_rt, D_T_use_rt, E_Reg_Addr, E_T_new, E_Reg_W);
    assign haz_m_rs = reg_hazard(D_rs, D_T_use_rs, M_Reg_Addr, M_T_new, M_Reg_W);
    assign haz_m_rt = reg_hazard(D_rt, D_T_use_rt, M_Reg_Addr, M_T_new, M_Reg_W);
    // The start cycle itself must also hold an MD op, before busy has risen.
    assign haz_md   = D_is_md && (E_md_start || md_busy);

    assign stall = haz_e_rs | haz_e_rt | haz_m_rs | haz_m_rt | haz_md;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It sits beside the D stage and compares the D-stage source registers and their T_use against the E/M-stage destinations and T_new. It also owns the busy timer of the multiply/divide unit. Its outputs freeze PC and the F/D register, insert a bubble into D/E, and report MDU completion and a stall-cycle count.

## Interface
- MULT_CYCLES, 5, E-stage cycles a mult/multu occupies the MDU
- DIV_CYCLES, 10, E-stage cycles a div/divu occupies the MDU
- CNT_W, 4, width of the MDU busy counter; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- D_rs, D_rt  in  5 each  D-stage source register numbers
- D_T_use_rs, D_T_use_rt  in  3 each  cycles until the D-stage instruction needs rs/rt; 3'b111 means not used
- D_is_md  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- E_Reg_Addr  in  5  E-stage destination
- E_T_new  in  3  E-stage cycles until the result is available
- E_Reg_W  in  1  E-stage writes the register file
- M_Reg_Addr, M_T_new, M_Reg_W  in  5/3/1  same fields for the M stage
- E_md_start  in  1  E-stage instruction starts the MDU this cycle
- E_md_is_div  in  1  qualifies E_md_start: 1 = div/divu, 0 = mult/multu
- stall  out  1  freeze PC and F/D, clear D/E
- md_busy  out  1  MDU computing
- md_done  out  1  one-cycle pulse on the last busy cycle
- stall_cnt  out  32  total stall cycles since reset; saturates

## Operation
- Register hazard for stage X ∈ {E, M}, source s ∈ {rs, rt}: D_s == X_Reg_Addr && X_Reg_W && D_s != 0 && D_T_use_s < X_T_new.
- Register 0 never raises a hazard.
- T_new == 0 never stalls; the forwarding network covers that case.
- MDU hazard: D_is_md && (E_md_start || md_busy).
- stall = OR of all four register hazards and the MDU hazard. It is purely combinational from the inputs and the current state.
- Busy timer:
  - When E_md_start is sampled, cnt loads DIV_CYCLES if E_md_is_div, otherwise MULT_CYCLES.
  - When cnt != 0, cnt decrements by 1 each cycle.
  - md_busy = (cnt != 0).
  - md_done = (cnt == 1).
- E_md_start arriving while md_busy is high reloads the counter. Only the new operation counts, and no md_done is produced for the aborted one.
- stall_cnt increments in every cycle where stall == 1 at the rising edge. It holds at 32'hFFFF_FFFF.

## Timing
- Reset values: cnt = 0, md_busy = 0, md_done = 0, stall_cnt = 0. stall follows the inputs combinationally (0 if no hazard).
- Reset asserted mid-operation clears cnt immediately (asynchronously). md_busy and md_done fall in the same instant, with no pending md_done.
- MDU start, with E_md_start high at edge t0:
  - md_busy is high in cycles t0+1 through t0+N (N = MULT_CYCLES or DIV_CYCLES).
  - md_done is high in cycle t0+N only.
  - md_busy is low from t0+N+1.
  - A D-stage MD instruction stalls during the start cycle and cycles t0+1..t0+N. It issues in t0+N+1.
- Register-hazard latency is 0 cycles: stall rises in the same cycle the hazard pattern appears on the inputs.
- stall_cnt updates one edge after the stalled cycle.

## Structure
- Shared package `pipe_pkg` holds:
  - T_NEW_W = 3 and T_USE_NONE = 3'b111
  - MULT_CYCLES and DIV_CYCLES defaults
  - the MD-op encoding for E_md_is_div
- Sub-module `md_busy_timer` contains the loadable down-counter plus the md_busy/md_done decode. It has clk, reset, start, is_div, busy and done ports.
- Hazard compare logic and stall_cnt stay in the top level.

## Test plan
- Reset during div with cnt = 6: reset=1 → md_busy=0, md_done=0, stall_cnt=0 immediately; no md_done after release.
- Load-use hazard, no forwarding: D_rs=5, D_T_use_rs=0, E_Reg_Addr=5, E_Reg_W=1, E_T_new=2 → stall=1. Hold 2 cycles with E_T_new→M_T_new=1 → stall=1 then 0; stall_cnt=2.
- Register 0 and T_new == 0 cases:
  - D_rt=0 against E_Reg_Addr=0, E_Reg_W=1, E_T_new=2 → stall=0.
  - D_rt=7, E_Reg_Addr=7, E_T_new=0 → stall=0.
- mult then mflo: E_md_start=1, E_md_is_div=0 at t0 with D_is_md=1 → stall high t0..t0+5; md_done only at t0+5; stall=0 at t0+6; stall_cnt=6.
- Restart: div started at t0, new mult start at t0+3 → md_busy high through t0+8; single md_done at t0+8.
- Saturation: force 2^32+3 stalled cycles (or preload via hierarchical force to 32'hFFFF_FFFE, then 3 stall cycles) → stall_cnt=32'hFFFF_FFFF, with no wrap to 0.
